// File: rtl/uart_bus_bridge.sv
// rtl/uart_bus_bridge.sv - APB / AHB-Lite / Avalon-MM slave front-end for the UART register block
module uart_bus_bridge #(
    parameter string BUS = "apb",
    parameter int    AW  = 32,
    parameter int    DW  = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr,
    input  logic [AW-1:0] haddr,
    input  logic [DW-1:0] hwdata,
    input  logic          hwrite,
    input  logic          hsel,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    output logic [DW-1:0] hrdata,
    output logic          hready,
    output logic [1:0]    hresp,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] writedata,
    input  logic          write,
    input  logic          chipselect,
    output logic [DW-1:0] readdata,
    output logic [AW-1:0] addr,
    output logic          re,
    output logic          we,
    output logic [DW-1:0] wd,
    input  logic [DW-1:0] rd
);
    localparam bit IS_APB = (BUS == "apb");
    localparam bit IS_AHB = (BUS == "ahb");
    localparam bit IS_AVL = (BUS == "avalon");

    typedef enum logic [1:0] {IDLE, WDATA, RD1, RD2} ahb_state_t;

    ahb_state_t    state;
    logic [AW-1:0] a_addr;
    logic          avl_rvalid;
    logic          ahb_ready;
    logic          accept;
    logic          unused_ahb;

    // hsize/hburst carry no meaning for 32-bit single transfers; htrans[0] only splits NONSEQ/SEQ
    assign unused_ahb = ^{hsize, hburst, htrans[0]};

    assign ahb_ready = (state != RD1);
    assign accept    = IS_AHB && hsel && htrans[1] && ahb_ready;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state      <= IDLE;
            a_addr     <= '0;
            avl_rvalid <= 1'b0;
        end else begin
            avl_rvalid <= IS_AVL && chipselect && !write;
            case (state)
                RD1: state <= RD2;
                default: begin
                    if (accept) begin
                        state  <= hwrite ? WDATA : RD1;
                        a_addr <= haddr;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Strobes are gated by reset so nothing reaches the core while it is held
    always_comb begin
        addr     = '0;
        re       = 1'b0;
        we       = 1'b0;
        wd       = '0;
        prdata   = '0;
        hrdata   = '0;
        readdata = '0;
        pready   = IS_APB;
        pslverr  = 1'b0;
        hready   = IS_AHB && ahb_ready;
        hresp    = 2'b00;
        if (!rstn) begin
            if (IS_APB) begin
                if (psel && !penable && !pwrite) begin
                    re   = 1'b1;
                    addr = paddr;
                end else if (psel && penable && pwrite) begin
                    we   = 1'b1;
                    addr = paddr;
                    wd   = pwdata;
                end
                if (psel && penable && !pwrite)
                    prdata = rd;
            end else if (IS_AHB) begin
                case (state)
                    WDATA: begin
                        we   = 1'b1;
                        addr = a_addr;
                        wd   = hwdata;
                    end
                    RD1: begin
                        re   = 1'b1;
                        addr = a_addr;
                    end
                    RD2:     hrdata = rd;
                    default: ;
                endcase
            end else if (IS_AVL) begin
                if (chipselect) begin
                    addr = address;
                    if (write) begin
                        we = 1'b1;
                        wd = writedata;
                    end else begin
                        re = 1'b1;
                    end
                end
                if (avl_rvalid)
                    readdata = rd;
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb/tb_uart_bus_bridge.sv - directed self-checking bench for uart_bus_bridge in all three bus modes
module tb_uart_bus_bridge;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic        hwrite = 0, hsel = 0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'd2, hburst = 3'd0;
    logic [31:0] address = '0, writedata = '0;
    logic        write = 0, chipselect = 0;
    logic [31:0] rd = '0;

    logic [31:0] p_prdata, p_hrdata, p_readdata, p_addr, p_wd;
    logic        p_pready, p_pslverr, p_hready, p_re, p_we;
    logic [1:0]  p_hresp;
    logic [31:0] h_prdata, h_hrdata, h_readdata, h_addr, h_wd;
    logic        h_pready, h_pslverr, h_hready, h_re, h_we;
    logic [1:0]  h_hresp;
    logic [31:0] v_prdata, v_hrdata, v_readdata, v_addr, v_wd;
    logic        v_pready, v_pslverr, v_hready, v_re, v_we;
    logic [1:0]  v_hresp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_bus_bridge #(.BUS("apb")) u_apb (
        .clk(clk), .rstn(rstn),
        .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable), .pwrite(pwrite),
        .prdata(p_prdata), .pready(p_pready), .pslverr(p_pslverr),
        .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .hsel(hsel), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hrdata(p_hrdata), .hready(p_hready), .hresp(p_hresp),
        .address(address), .writedata(writedata), .write(write), .chipselect(chipselect),
        .readdata(p_readdata), .addr(p_addr), .re(p_re), .we(p_we), .wd(p_wd), .rd(rd));

    uart_bus_bridge #(.BUS("ahb")) u_ahb (
        .clk(clk), .rstn(rstn),
        .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable), .pwrite(pwrite),
        .prdata(h_prdata), .pready(h_pready), .pslverr(h_pslverr),
        .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .hsel(hsel), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hrdata(h_hrdata), .hready(h_hready), .hresp(h_hresp),
        .address(address), .writedata(writedata), .write(write), .chipselect(chipselect),
        .readdata(h_readdata), .addr(h_addr), .re(h_re), .we(h_we), .wd(h_wd), .rd(rd));

    uart_bus_bridge #(.BUS("avalon")) u_avl (
        .clk(clk), .rstn(rstn),
        .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable), .pwrite(pwrite),
        .prdata(v_prdata), .pready(v_pready), .pslverr(v_pslverr),
        .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .hsel(hsel), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hrdata(v_hrdata), .hready(v_hready), .hresp(v_hresp),
        .address(address), .writedata(writedata), .write(write), .chipselect(chipselect),
        .readdata(v_readdata), .addr(v_addr), .re(v_re), .we(v_we), .wd(v_wd), .rd(rd));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset state ----
        cyc(); cyc();
        #3;
        check("rst_apb_pready", p_pready, 1);
        check("rst_ahb_hready", h_hready, 1);
        check("rst_avl_hready", v_hready, 0);
        check("rst_strobes", {p_re, p_we, h_re, h_we, v_re, v_we}, 0);
        check("rst_data", {p_prdata, h_hrdata}, 0);
        check("rst_resp", {p_pslverr, h_hresp}, 0);
        cyc();
        rstn = 1'b0;

        // ---- APB write 0x55 to 0x4 ----
        cyc();
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h4; pwdata = 32'h55;
        #3;
        check("apb_wr_setup_we", {p_we, p_re}, 0);
        cyc();
        penable = 1;
        #3;
        check("apb_wr_we", p_we, 1);
        check("apb_wr_addr", p_addr, 32'h4);
        check("apb_wr_wd", p_wd, 32'h55);
        check("apb_wr_pready", {p_pready, p_pslverr}, 2'b10);
        check("apb_wr_other", {h_we, h_re, v_we, v_re}, 0);
        cyc();
        psel = 0; penable = 0; pwrite = 0;
        #3;
        check("apb_wr_done", {p_we, p_re}, 0);

        // ---- APB read 0x8, rd=0xA5 ----
        cyc();
        psel = 1; paddr = 32'h8;
        #3;
        check("apb_rd_re", {p_re, p_we}, 2'b10);
        check("apb_rd_addr", p_addr, 32'h8);
        check("apb_rd_setup_prdata", p_prdata, 0);
        cyc();
        penable = 1; rd = 32'hA5;
        #3;
        check("apb_rd_prdata", p_prdata, 32'hA5);
        check("apb_rd_access_re", p_re, 0);
        check("avl_apb_prdata", v_prdata, 0);
        cyc();
        psel = 0; penable = 0; rd = 0;

        // ---- AHB write 0x0 then read 0x4 ----
        cyc();
        hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h0;
        #3;
        check("ahb_c1_hready", h_hready, 1);
        check("ahb_c1_strobe", {h_we, h_re}, 0);
        cyc();
        hwdata = 32'hDEAD; haddr = 32'h4; hwrite = 0;
        #3;
        check("ahb_c2_we", {h_we, h_re}, 2'b10);
        check("ahb_c2_addr", h_addr, 32'h0);
        check("ahb_c2_wd", h_wd, 32'hDEAD);
        check("ahb_c2_hready", h_hready, 1);
        cyc();
        hsel = 0; htrans = 2'b00; hwdata = 0;
        #3;
        check("ahb_c3_re", {h_re, h_we}, 2'b10);
        check("ahb_c3_addr", h_addr, 32'h4);
        check("ahb_c3_hready", h_hready, 0);
        cyc();
        rd = 32'h77;
        #3;
        check("ahb_c4_hrdata", h_hrdata, 32'h77);
        check("ahb_c4_hready", h_hready, 1);
        check("ahb_c4_strobe", {h_re, h_we}, 0);
        check("avl_ahb_hrdata", v_hrdata, 0);
        check("ahb_hresp", h_hresp, 0);
        cyc();
        rd = 0;
        #3;
        check("ahb_c5_hrdata", h_hrdata, 0);

        // ---- reset during RD1 ----
        cyc();
        hsel = 1; htrans = 2'b10; hwrite = 0; haddr = 32'h8;
        cyc();
        hsel = 0; htrans = 2'b00;
        #1;
        check("ahb_rd1_re", h_re, 1);
        rstn = 1'b1;
        #1;
        check("ahb_rst_strobe", {h_re, h_we}, 0);
        check("ahb_rst_hready", h_hready, 1);
        cyc();
        rd = 32'h99;
        #3;
        check("ahb_rst_hrdata", h_hrdata, 0);
        cyc();
        rstn = 1'b0;
        #3;
        check("ahb_post_rst_idle", {h_re, h_we, h_hrdata}, 0);
        cyc();
        rd = 0; hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'hC;
        #3;
        check("ahb_post_rst_c1", {h_hready, h_re, h_we}, 3'b100);
        cyc();
        hsel = 0; htrans = 2'b00; hwdata = 32'hBEEF;
        #3;
        check("ahb_post_rst_we", {h_we, h_re}, 2'b10);
        check("ahb_post_rst_addr", h_addr, 32'hC);
        check("ahb_post_rst_wd", h_wd, 32'hBEEF);
        cyc();
        hwdata = 0;

        // ---- Avalon write then 3 pipelined reads ----
        cyc();
        chipselect = 1; write = 1; address = 32'hC; writedata = 32'h1234;
        #3;
        check("avl_wr_we", {v_we, v_re}, 2'b10);
        check("avl_wr_addr", v_addr, 32'hC);
        check("avl_wr_wd", v_wd, 32'h1234);
        cyc();
        write = 0; address = 32'h0;
        #3;
        check("avl_rd0_re", {v_re, v_we}, 2'b10);
        check("avl_rd0_addr", v_addr, 32'h0);
        check("avl_rd0_readdata", v_readdata, 0);
        cyc();
        address = 32'h4; rd = 32'h100;
        #3;
        check("avl_rd1_re", v_re, 1);
        check("avl_rd1_addr", v_addr, 32'h4);
        check("avl_rd1_readdata", v_readdata, 32'h100);
        cyc();
        address = 32'h8; rd = 32'h104;
        #3;
        check("avl_rd2_addr", v_addr, 32'h8);
        check("avl_rd2_readdata", v_readdata, 32'h104);
        cyc();
        chipselect = 0; rd = 32'h108;
        #3;
        check("avl_rd3_readdata", v_readdata, 32'h108);
        check("avl_rd3_strobe", {v_re, v_we}, 0);
        cyc();
        #3;
        check("avl_idle_readdata", v_readdata, 0);

        // ---- Avalon mode ignores APB/AHB stimulus ----
        cyc();
        psel = 1; pwrite = 0; paddr = 32'h10; hsel = 1; htrans = 2'b10; hwrite = 0;
        #3;
        check("avl_ign_setup", {v_re, v_we, v_prdata, v_hrdata}, 0);
        cyc();
        penable = 1; hsel = 0; htrans = 2'b00; rd = 32'h5A;
        #3;
        check("avl_ign_access", {v_re, v_we, v_prdata, v_hrdata}, 0);
        check("avl_ign_ready", {v_pready, v_hready}, 0);
        cyc();
        psel = 0; penable = 0;
        #3;
        check("avl_ign_ahb_rd1", {v_re, v_we, v_hrdata}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Bus front-end for the UART peripheral: converts one of three system-bus slave protocols (APB, AHB-Lite, Avalon-MM) into the UART core's simple register interface (addr/re/we/wd/rd). A parameter selects which bus port is live. The bridge sits between the SoC interconnect and the UART register block and adds no register state of its own beyond protocol tracking.

## Interface
- BUS, default "apb": live port; one of "apb", "ahb", "avalon".
- AW, default 32: address width.
- DW, default 32: data width.

- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  reset; asynchronous, active-high (1 = reset)
- paddr  in  AW; pwdata  in  DW; psel, penable, pwrite  in  1 — APB request
- prdata  out  DW; pready, pslverr  out  1 — APB response
- haddr  in  AW; hwdata  in  DW; hwrite, hsel  in  1; htrans  in  2; hsize, hburst  in  3 — AHB request
- hrdata  out  DW; hready  out  1; hresp  out  2 — AHB response
- address  in  AW; writedata  in  DW; write, chipselect  in  1 — Avalon request
- readdata  out  DW — Avalon response
- addr  out  AW; re, we  out  1; wd  out  DW — core request
- rd  in  DW — core read data, valid the cycle after re

## Operation
- Inactive ports: all outputs driven 0, inputs ignored.
- Core contract: re/we are single-cycle strobes, never both high; rd sampled exactly one cycle after re.
- APB (zero wait states): pready=1, pslverr=0 constantly.
  - Setup read (psel & !penable & !pwrite): re=1, addr=paddr.
  - Access write (psel & penable & pwrite): we=1, addr=paddr, wd=pwdata.
  - Access read: prdata=rd (combinational); otherwise prdata=0.
- AHB-Lite: hresp=0 (OKAY) always; hsize/hburst ignored (32-bit single transfers assumed).
  - Address phase accepted when hsel & htrans[1] & hready; register haddr, hwrite, valid flag.
  - States: IDLE, WDATA, RD1, RD2.
  - IDLE: on accepted write -> WDATA; accepted read -> RD1.
  - WDATA: we=1, addr=registered addr, wd=hwdata, hready=1; new address phase may be accepted same cycle (-> WDATA/RD1/IDLE).
  - RD1: re=1, addr=registered addr, hready=0 (one wait state); -> RD2.
  - RD2: hrdata=rd, hready=1; may accept next address phase.
  - hready=1 in IDLE; hrdata=0 outside RD2.
- Avalon (read latency 1, no waitrequest):
  - chipselect & write: we=1, addr=address, wd=writedata.
  - chipselect & !write: re=1, addr=address; readdata=rd next cycle (registered-valid flag), else 0.
  - Back-to-back reads pipeline at one per cycle.

## Timing
- Reset (async assert, sync release): AHB state IDLE, valid flags 0; re=we=0, addr=wd=0, prdata=hrdata=readdata=0, pready=1 (APB mode), hready=1 (AHB mode), pslverr=0, hresp=0.
- APB write: 2 cycles (setup, access), we in access. APB read: re in setup, data in access.
- AHB write: 0 wait states; AHB read: 1 wait state (3 cycles address-to-data-accept).
- Avalon write: 1 cycle; read: data 1 cycle after request.
- Reset mid-transfer aborts it; no strobe issued after reset asserts; pending AHB read returns to IDLE with hready=1.
- htrans IDLE/BUSY or hsel=0 in address phase: no strobe, state -> IDLE after current data phase.

## Test plan
- APB write 0x0000_0055 to paddr 0x4 -> exactly one cycle we=1, addr=0x4, wd=0x55, during access phase; pready=1.
- APB read paddr 0x8, core rd=0xA5 -> re one cycle in setup; prdata=0xA5 in access phase.
- AHB write addr 0x0 then read addr 0x4 back-to-back (NONSEQ) -> we in cycle 2 with wd=hwdata; re in cycle 3 (hready=0); hrdata=rd, hready=1 in cycle 4; never re&we together.
- Avalon: write 0x1234 to 0xC then 3 consecutive reads 0x0,0x4,0x8 -> we one cycle; re each cycle; readdata returns matching rd values one cycle later each.
- Reset asserted during AHB RD1 -> re=we=0 immediately, hready=1, state IDLE; after release first new transfer behaves normally.
- BUS="avalon": APB/AHB stimulus toggled -> no core strobes, prdata=hrdata=0.
